// File: rtl/seg_scan_if.sv
// seg_scan_if: display-bus sample lines plus the decoded-frame valid/ready channel.
interface seg_scan_if;
  logic [3:0]  an_L;
  logic [6:0]  seg_L;
  logic [15:0] out_data;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  modport slave (
    input  an_L, seg_L, out_ready,
    output out_data, out_err, out_valid, overrun
  );

  modport master (
    output an_L, seg_L, out_ready,
    input  out_data, out_err, out_valid, overrun
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a scanned 4-digit active-low 7-segment bus, captures
// each digit once its pattern holds steady, decodes it to a nibble and hands the
// assembled frame out over valid/ready. Optional macro SEGDEC_HEX_EN enables
// decoding of the A-F glyphs; without it only 0-9 decode cleanly.
module seg_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic     clk,
  input logic     rst_n,
  seg_scan_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_HIT = CNT_W'(STABLE_CYCLES - 2);

  typedef enum logic {COLLECT, FULL} state_t;

  state_t           state, state_next;
  logic [3:0]       smp_an;
  logic [6:0]       smp_seg;
  logic [CNT_W-1:0] stab_cnt;
  logic [15:0]      work_data;
  logic [3:0]       work_err;
  logic [3:0]       mask;
  logic [15:0]      data_q;
  logic [3:0]       err_q;
  logic             valid_q;
  logic             overrun_q;

  logic             same_c;
  logic             legal_c;
  logic             capture_c;
  logic [1:0]       slot_c;
  logic [3:0]       nib_c;
  logic             bad_c;
  logic             load_c;
  logic             drop_c;

  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;

  // New bus sample matches the held sample; a capture fires as the run count reaches its target
  assign same_c    = (bus.an_L == smp_an) && (bus.seg_L == smp_seg);
  assign capture_c = same_c && legal_c && (stab_cnt == CNT_HIT);

  // Strobe legality and slot index: exactly one strobe bit low
  always_comb begin
    legal_c = 1'b1;
    slot_c  = 2'd0;
    case (smp_an)
      4'b1110: slot_c = 2'd0;
      4'b1101: slot_c = 2'd1;
      4'b1011: slot_c = 2'd2;
      4'b0111: slot_c = 2'd3;
      default: legal_c = 1'b0;
    endcase
  end

  // Segment pattern to nibble; anything outside the glyph table is flagged
  always_comb begin
    nib_c = 4'h0;
    bad_c = 1'b0;
    case (smp_seg)
      7'h40: nib_c = 4'h0;
      7'h79: nib_c = 4'h1;
      7'h24: nib_c = 4'h2;
      7'h30: nib_c = 4'h3;
      7'h19: nib_c = 4'h4;
      7'h12: nib_c = 4'h5;
      7'h02: nib_c = 4'h6;
      7'h78: nib_c = 4'h7;
      7'h00: nib_c = 4'h8;
      7'h10: nib_c = 4'h9;
`ifdef SEGDEC_HEX_EN
      7'h08: nib_c = 4'hA;
      7'h03: nib_c = 4'hB;
      7'h46: nib_c = 4'hC;
      7'h21: nib_c = 4'hD;
      7'h06: nib_c = 4'hE;
      7'h0E: nib_c = 4'hF;
`endif
      default: bad_c = 1'b1;
    endcase
  end

  // Input sampling and saturating stability counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_an   <= 4'hF;
      smp_seg  <= 7'h7F;
      stab_cnt <= '0;
    end else begin
      smp_an  <= bus.an_L;
      smp_seg <= bus.seg_L;
      if (same_c && legal_c) begin
        if (stab_cnt != CNT_MAX) stab_cnt <= stab_cnt + CNT_W'(1);
      end else begin
        stab_cnt <= '0;
      end
    end
  end

  // Working frame: slot writes on capture, mask clears when the frame leaves FULL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_data <= '0;
      work_err  <= '0;
      mask      <= '0;
    end else begin
      if (load_c || drop_c) mask <= '0;
      if (capture_c) begin
        mask[slot_c]                     <= 1'b1;
        work_data[{slot_c, 2'b00} +: 4]  <= nib_c;
        work_err[slot_c]                 <= bad_c;
      end
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  // Frame FSM next state: in FULL either load the output register or drop the frame
  always_comb begin
    state_next = state;
    load_c     = 1'b0;
    drop_c     = 1'b0;
    case (state)
      COLLECT: if (mask == 4'hF) state_next = FULL;
      FULL: begin
        state_next = COLLECT;
        if (!valid_q || bus.out_ready) load_c = 1'b1;
        else                           drop_c = 1'b1;
      end
      default: state_next = COLLECT;
    endcase
  end

  // Output register, handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      err_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (load_c) begin
        data_q  <= work_data;
        err_q   <= work_err;
        valid_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (drop_c) overrun_q <= 1'b1;
    end
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Reader for a scanned 4-digit, active-low seven-segment display bus: the opposite direction of our hex-to-segment encoder. It watches the digit strobe and segment lines and waits for each digit's pattern to hold steady. It then decodes each steady pattern back to a 4-bit value and delivers the assembled 4-digit frame over a valid/ready handshake. It sits on the board-test side, self-checking what the display path actually drives.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is captured (legal range 2..255).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous and active-low.
- an_L  in  4  digit strobe, active-low; a legal strobe has exactly one bit low.
- seg_L  in  7  segments {g,f,e,d,c,b,a}, active-low.
- out_data  out  16  frame; digit k in bits [4k+3:4k].
- out_err  out  4  per-digit flag: pattern not decodable.
- out_valid  out  1  frame available.
- out_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky: a complete frame was dropped.

## Operation
- Input stage: an_L and seg_L are registered every cycle into smp_an and smp_seg. The previous sample is kept for comparison.
- Stability counter: it increments while the new sample equals the previous sample and smp_an is one-hot-low. It clears to 0 on any change or on an illegal strobe (0 or 2+ bits low). It saturates once it reaches STABLE_CYCLES-1.
- Capture: happens exactly once per stable run, on the cycle the counter reaches STABLE_CYCLES-1. A new capture requires the input to change first.
- On capture, the digit slot k selected by the low strobe bit is written:
  - nibble = decode(smp_seg);
  - err[k] = pattern not in table;
  - mask[k] = 1.
- A re-capture of an already-filled slot overwrites that slot.
- Decode table (seg_L hex → nibble):
  - digits 0–7: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7;
  - digits 8–F: 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F.
  - Every other pattern, including 7F (blank), gives nibble 0 and err = 1.
- Frame FSM states:
  - COLLECT: mask != F.
  - FULL: mask == F, the cycle after the fourth slot fills.
- Leaving FULL:
  - If the output register is empty, or is being accepted this cycle (out_valid & out_ready), working data and err are copied to out_data/out_err, out_valid is set, and mask clears. The FSM returns to COLLECT.
  - Otherwise the frame is dropped, overrun is set, and mask clears. The FSM returns to COLLECT.
- Handshake: out_valid holds, with out_data/out_err stable, until the cycle out_valid & out_ready is sampled high. A simultaneous load and accept keeps out_valid high with the new data.
- overrun clears only on reset.

## Timing
- Reset values, all outputs and state: out_data 0, out_err 0, out_valid 0, overrun 0, mask 0, counter 0, samples an = F, seg = 7F, FSM in COLLECT.
- Capture latency: an input held constant from edge t is sampled at t and captured at edge t+STABLE_CYCLES-1.
- Frame latency: out_valid rises 2 edges after the fourth capture (one edge into FULL, one edge to load).
- Reset asserted mid-frame discards partial slots. No out_valid pulse occurs until a full 4-digit set is recollected.
- A strobe change and a segment change in the same cycle count as one change. The counter restarts.

## Configuration
- SEGDEC_HEX_EN defined: A–F patterns decode to 0xA–0xF with err = 0.
- SEGDEC_HEX_EN undefined: the block is decimal-only. Patterns 08, 03, 46, 21, 06, 0E give nibble 0 and err = 1, the same as undefined patterns.

## Test plan
- Scan digits 0..3 showing 1,2,3,4 (an_L E,D,B,7; seg_L 79,24,30,19), each held 6 cycles with out_ready = 1 → out_data = 4321, out_err = 0, one out_valid.
- Hold a digit for only STABLE_CYCLES-1 cycles between changes → no capture, mask stays 0, no out_valid.
- Digit 2 shows 7F, and separately 55 → out_err = 4, nibble 2 = 0, other digits correct.
- With out_ready = 0, scan two full frames → first frame held on out_data, second dropped, overrun = 1. Then raise out_ready → one accept, out_valid falls.
- With out_ready = 1, scan digits A, B, C, F (seg_L 08, 03, 46, 0E):
  - SEGDEC_HEX_EN defined → out_data = FCBA, out_err = 0;
  - SEGDEC_HEX_EN undefined → out_data = 0000, out_err = F.
- Assert rst_n low after 3 digits are captured, then scan one digit → no out_valid. A complete 4-digit rescan then yields a frame.
